// File: rtl/pic_pkg.sv
// ============================================================================
// pic_pkg: shared types, defaults and rotate helpers for the interrupt controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package pic_pkg;

  localparam int DEFAULT_NUM_IRQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_LAST = 1'b1
  } isr_state_t;

  // Rotate the low 'width' bits of v left by amt; bits at and above width are zero.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned amt,
                                       input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[(i + amt) % width] = v[i];
    end
    return r;
  endfunction

  // Rotate the low 'width' bits of v right by amt; bits at and above width are zero.
  function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned amt,
                                       input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[i] = v[(i + amt) % width];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isr_prio_find.sv
// ============================================================================
// isr_prio_find: one-hot highest-priority set bit under rotating priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module isr_prio_find
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int PTR_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [PTR_W-1:0]   lowest_prio,
  output logic [NUM_IRQ-1:0] first
);

  int unsigned        start;
  logic [NUM_IRQ-1:0] rot;
  logic [NUM_IRQ-1:0] iso;

  // The level just above lowest_prio is moved to bit 0, so the lowest set
  // bit of the rotated vector is the highest-priority request.
  always_comb begin
    if (32'(lowest_prio) >= 32'(NUM_IRQ - 1)) start = 0;
    else                                       start = 32'(lowest_prio) + 1;
    rot   = NUM_IRQ'(rotr(32'(vec), start, NUM_IRQ));
    iso   = rot & (~rot + NUM_IRQ'(1));
    first = NUM_IRQ'(rotl(32'(iso), start, NUM_IRQ));
  end

endmodule

`default_nettype wire

// File: rtl/isr_rotating.sv
// ============================================================================
// isr_rotating: in-service register with rotating priority, EOI forms and AEOI.
// Rev 1.0
// ============================================================================
`default_nettype none

module isr_rotating
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int PTR_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] grant,
  input  logic               inta_first,
  input  logic               inta_last,
  input  logic               aeoi_mode,
  input  logic               auto_rotate,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic               set_prio,
  input  logic [PTR_W-1:0]   eoi_level,
  input  logic               smm,
  input  logic [NUM_IRQ-1:0] special_mask,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] highest_in_service,
  output logic [PTR_W-1:0]   lowest_prio,
  output logic               busy
);

  isr_state_t         state, state_nxt;
  logic [NUM_IRQ-1:0] isr, isr_nxt, masked_isr, highest, eoi_clr, aeoi_clr;
  logic [PTR_W-1:0]   lp, lp_nxt, latched, latched_nxt, eoi_lvl;
  logic               eoi_valid, eoi_rot, aeoi_fire;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_IRQ-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  assign masked_isr = smm ? (isr & ~special_mask) : isr;

  isr_prio_find #(
    .NUM_IRQ (NUM_IRQ),
    .PTR_W   (PTR_W)
  ) u_prio_find (
    .vec         (masked_isr),
    .lowest_prio (lp),
    .first       (highest)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (inta_first) state_nxt = ST_WAIT_LAST;
      ST_WAIT_LAST: if (inta_first) state_nxt = ST_WAIT_LAST;
                    else if (inta_last) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Clears (EOI, then AEOI) apply before the INTA set, so a same-cycle grant survives.
  always_comb begin
    eoi_valid = eoi_cmd && (32'(eoi_level) < 32'(NUM_IRQ));
    eoi_clr   = '0;
    eoi_lvl   = '0;
    if (eoi_valid && !set_prio) begin
      if (eoi_specific) begin
        eoi_clr = NUM_IRQ'(1) << eoi_level;
        eoi_lvl = eoi_level;
      end else begin
        eoi_clr = highest;
        eoi_lvl = onehot_idx(highest);
      end
    end
    eoi_rot   = eoi_rotate && (eoi_clr != '0);
    aeoi_fire = (state == ST_WAIT_LAST) && inta_last && aeoi_mode;
    aeoi_clr  = aeoi_fire ? (NUM_IRQ'(1) << latched) : '0;
    isr_nxt   = (isr & ~eoi_clr & ~aeoi_clr) | (inta_first ? grant : '0);

    lp_nxt = lp;
    if (eoi_valid && set_prio) lp_nxt = eoi_level;
    else if (eoi_rot)          lp_nxt = eoi_lvl;
    if (aeoi_fire && auto_rotate) lp_nxt = latched;

    latched_nxt = inta_first ? onehot_idx(grant) : latched;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isr     <= '0;
      lp      <= PTR_W'(NUM_IRQ - 1);
      latched <= '0;
    end else begin
      isr     <= isr_nxt;
      lp      <= lp_nxt;
      latched <= latched_nxt;
    end
  end

  assign in_service         = isr;
  assign highest_in_service = highest;
  assign lowest_prio        = lp;
  assign busy               = (state == ST_WAIT_LAST);

endmodule

`default_nettype wire

// File: tb/tb_isr_rotating.sv
// ============================================================================
// tb_isr_rotating: directed scenarios plus randomized run against a reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_isr_rotating;

  logic clk = 1'b0;
  logic reset, inta_first, inta_last, aeoi_mode, auto_rotate;
  logic eoi_cmd, eoi_specific, eoi_rotate, set_prio, smm;

  logic [7:0]  grant8, mask8, isr8, hi8;
  logic [2:0]  lvl8, lp8;
  logic        busy8;
  logic [15:0] grant16, mask16, isr16, hi16;
  logic [3:0]  lvl16, lp16;
  logic        busy16;
  logic [11:0] grant12, mask12, isr12, hi12;
  logic [3:0]  lvl12, lp12;
  logic        busy12;

  int checks = 0;
  int errors = 0;

  // Reference model state for the 8-level instance.
  logic [7:0] m_isr;
  int         m_lp, m_lat;
  bit         m_busy;

  always #5 clk = ~clk;

  isr_rotating #(.NUM_IRQ(8)) u_dut8 (
    .clk(clk), .reset(reset), .grant(grant8), .inta_first(inta_first), .inta_last(inta_last),
    .aeoi_mode(aeoi_mode), .auto_rotate(auto_rotate), .eoi_cmd(eoi_cmd),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .set_prio(set_prio),
    .eoi_level(lvl8), .smm(smm), .special_mask(mask8), .in_service(isr8),
    .highest_in_service(hi8), .lowest_prio(lp8), .busy(busy8));

  isr_rotating #(.NUM_IRQ(16)) u_dut16 (
    .clk(clk), .reset(reset), .grant(grant16), .inta_first(inta_first), .inta_last(inta_last),
    .aeoi_mode(aeoi_mode), .auto_rotate(auto_rotate), .eoi_cmd(eoi_cmd),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .set_prio(set_prio),
    .eoi_level(lvl16), .smm(smm), .special_mask(mask16), .in_service(isr16),
    .highest_in_service(hi16), .lowest_prio(lp16), .busy(busy16));

  isr_rotating #(.NUM_IRQ(12)) u_dut12 (
    .clk(clk), .reset(reset), .grant(grant12), .inta_first(inta_first), .inta_last(inta_last),
    .aeoi_mode(aeoi_mode), .auto_rotate(auto_rotate), .eoi_cmd(eoi_cmd),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .set_prio(set_prio),
    .eoi_level(lvl12), .smm(smm), .special_mask(mask12), .in_service(isr12),
    .highest_in_service(hi12), .lowest_prio(lp12), .busy(busy12));

  task automatic tick();
    @(posedge clk);
    #1;
    inta_first = 1'b0; inta_last = 1'b0; eoi_cmd = 1'b0;
    eoi_specific = 1'b0; eoi_rotate = 1'b0; set_prio = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    aeoi_mode = 1'b0; auto_rotate = 1'b0; smm = 1'b0;
    grant8 = '0; mask8 = '0; lvl8 = '0;
    grant16 = '0; mask16 = '0; lvl16 = '0;
    grant12 = '0; mask12 = '0; lvl12 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL reset_isr got %h want 00", isr8); end
    checks++; if (lp8 !== 3'd7) begin errors++; $display("FAIL reset_lp got %0d want 7", lp8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++; if (hi8 !== 8'h00) begin errors++; $display("FAIL reset_hi got %h want 00", hi8); end
  endtask

  task automatic test_nonspecific_eoi();
    do_reset();
    grant8 = 8'h08; inta_first = 1'b1; tick();
    checks++; if (isr8 !== 8'h08) begin errors++; $display("FAIL nse_set got %h want 08", isr8); end
    checks++; if (hi8 !== 8'h08) begin errors++; $display("FAIL nse_hi got %h want 08", hi8); end
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL nse_busy got %b want 1", busy8); end
    inta_last = 1'b1; tick();
    eoi_cmd = 1'b1; tick();
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL nse_clr got %h want 00", isr8); end
    checks++; if (hi8 !== 8'h00) begin errors++; $display("FAIL nse_hi0 got %h want 00", hi8); end
    checks++; if (lp8 !== 3'd7) begin errors++; $display("FAIL nse_lp got %0d want 7", lp8); end
  endtask

  task automatic test_rotate_eoi();
    do_reset();
    eoi_cmd = 1'b1; set_prio = 1'b1; lvl8 = 3'd3; tick();
    grant8 = 8'h02; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    grant8 = 8'h20; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    checks++; if (isr8 !== 8'h22) begin errors++; $display("FAIL rot_isr got %h want 22", isr8); end
    checks++; if (hi8 !== 8'h20) begin errors++; $display("FAIL rot_hi got %h want 20", hi8); end
    eoi_cmd = 1'b1; eoi_rotate = 1'b1; tick();
    checks++; if (isr8 !== 8'h02) begin errors++; $display("FAIL rot_clr got %h want 02", isr8); end
    checks++; if (lp8 !== 3'd5) begin errors++; $display("FAIL rot_lp got %0d want 5", lp8); end
  endtask

  task automatic test_aeoi();
    do_reset();
    aeoi_mode = 1'b1; auto_rotate = 1'b1;
    grant8 = 8'h10; inta_first = 1'b1; tick();
    checks++; if (isr8 !== 8'h10) begin errors++; $display("FAIL aeoi_set got %h want 10", isr8); end
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL aeoi_busy got %b want 1", busy8); end
    inta_last = 1'b1; tick();
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL aeoi_clr got %h want 00", isr8); end
    checks++; if (lp8 !== 3'd4) begin errors++; $display("FAIL aeoi_lp got %0d want 4", lp8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL aeoi_idle got %b want 0", busy8); end
  endtask

  task automatic test_special_mask();
    do_reset();
    grant8 = 8'h04; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    grant8 = 8'h08; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    checks++; if (hi8 !== 8'h04) begin errors++; $display("FAIL smm_off_hi got %h want 04", hi8); end
    smm = 1'b1; mask8 = 8'h04; #1;
    checks++; if (hi8 !== 8'h08) begin errors++; $display("FAIL smm_hi got %h want 08", hi8); end
    eoi_cmd = 1'b1; eoi_specific = 1'b1; lvl8 = 3'd2; tick();
    checks++; if (isr8 !== 8'h08) begin errors++; $display("FAIL smm_eoi got %h want 08", isr8); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    grant8 = 8'h01; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    grant8 = 8'h01; inta_first = 1'b1;
    eoi_cmd = 1'b1; eoi_specific = 1'b1; lvl8 = 3'd0; tick();
    checks++; if (isr8 !== 8'h01) begin errors++; $display("FAIL simul_isr got %h want 01", isr8); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    grant12 = 12'h001; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    eoi_cmd = 1'b1; eoi_specific = 1'b1; lvl12 = 4'd13; tick();
    checks++; if (isr12 !== 12'h001) begin errors++; $display("FAIL oor_spec got %h want 001", isr12); end
    eoi_cmd = 1'b1; set_prio = 1'b1; lvl12 = 4'd13; tick();
    checks++; if (lp12 !== 4'd11) begin errors++; $display("FAIL oor_prio got %0d want 11", lp12); end
    eoi_cmd = 1'b1; eoi_rotate = 1'b1; lvl12 = 4'd13; tick();
    checks++; if (isr12 !== 12'h001) begin errors++; $display("FAIL oor_nse got %h want 001", isr12); end
    eoi_cmd = 1'b1; eoi_specific = 1'b1; lvl12 = 4'd0; tick();
    checks++; if (isr12 !== 12'h000) begin errors++; $display("FAIL oor_ctrl got %h want 000", isr12); end
  endtask

  task automatic test_wide();
    do_reset();
    grant16 = 16'h8000; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    grant16 = 16'h0001; inta_first = 1'b1; tick();
    inta_last = 1'b1; tick();
    eoi_cmd = 1'b1; set_prio = 1'b1; lvl16 = 4'd7; tick();
    checks++; if (hi16 !== 16'h8000) begin errors++; $display("FAIL wide_hi7 got %h want 8000", hi16); end
    eoi_cmd = 1'b1; set_prio = 1'b1; lvl16 = 4'd15; tick();
    checks++; if (hi16 !== 16'h0001) begin errors++; $display("FAIL wide_hi15 got %h want 0001", hi16); end
    checks++; if (isr16 !== 16'h8001) begin errors++; $display("FAIL wide_isr got %h want 8001", isr16); end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    aeoi_mode = 1'b1;
    grant8 = 8'h04; inta_first = 1'b1; tick();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy8); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL mid_idle got %b want 0", busy8); end
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL mid_isr got %h want 00", isr8); end
    inta_last = 1'b1; tick();
    checks++; if (busy8 !== 1'b0 || isr8 !== 8'h00 || lp8 !== 3'd7) begin
      errors++; $display("FAIL mid_last busy %b isr %h lp %0d want 0 00 7", busy8, isr8, lp8);
    end
  endtask

  function automatic int m_highest();
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (m_lp + k) % 8;
      if (m_isr[l] && !(smm && mask8[l])) return l;
    end
    return -1;
  endfunction

  task automatic model_step();
    int hi, lvl;
    logic [7:0] nisr;
    int nlp;
    nisr = m_isr; nlp = m_lp; hi = m_highest();
    if (reset) begin
      m_isr = '0; m_lp = 7; m_lat = 0; m_busy = 1'b0;
      return;
    end
    if (eoi_cmd) begin
      if (set_prio) nlp = int'(lvl8);
      else begin
        lvl = eoi_specific ? int'(lvl8) : hi;
        if (lvl >= 0) begin
          nisr[lvl] = 1'b0;
          if (eoi_rotate) nlp = lvl;
        end
      end
    end
    if (m_busy && inta_last && aeoi_mode) begin
      nisr[m_lat] = 1'b0;
      if (auto_rotate) nlp = m_lat;
    end
    if (inta_first) begin
      nisr = nisr | grant8;
      m_lat = 0;
      for (int i = 7; i >= 0; i--) if (grant8[i]) m_lat = i;
      m_busy = 1'b1;
    end else if (inta_last) begin
      m_busy = 1'b0;
    end
    m_isr = nisr; m_lp = nlp;
  endtask

  task automatic test_random();
    logic [7:0] exp_hi;
    int h;
    do_reset();
    m_isr = '0; m_lp = 7; m_lat = 0; m_busy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom % 97 == 0);
      inta_first   = ($urandom % 5 == 0);
      grant8       = ($urandom % 8 == 0) ? 8'h00 : 8'(1 << ($urandom % 8));
      inta_last    = ($urandom % 3 == 0);
      aeoi_mode    = 1'($urandom);
      auto_rotate  = 1'($urandom);
      eoi_cmd      = ($urandom % 4 == 0);
      eoi_specific = 1'($urandom);
      eoi_rotate   = 1'($urandom);
      set_prio     = ($urandom % 6 == 0);
      lvl8         = 3'($urandom);
      smm          = ($urandom % 3 == 0);
      mask8        = 8'($urandom);
      #1;
      h = m_highest();
      exp_hi = (h < 0) ? 8'h00 : 8'(1 << h);
      checks++; if (hi8 !== exp_hi) begin errors++; $display("FAIL rnd_hi cyc %0d got %h want %h", n, hi8, exp_hi); end
      model_step();
      tick();
      reset = 1'b0;
      checks++; if (isr8 !== m_isr) begin errors++; $display("FAIL rnd_isr cyc %0d got %h want %h", n, isr8, m_isr); end
      checks++; if (int'(lp8) != m_lp) begin errors++; $display("FAIL rnd_lp cyc %0d got %0d want %0d", n, lp8, m_lp); end
      checks++; if (busy8 !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", n, busy8, m_busy); end
    end
  endtask

  initial begin
    reset = 1'b1; inta_first = 1'b0; inta_last = 1'b0; eoi_cmd = 1'b0;
    eoi_specific = 1'b0; eoi_rotate = 1'b0; set_prio = 1'b0;
    test_reset();
    test_nonspecific_eoi();
    test_rotate_eoi();
    test_aeoi();
    test_special_mask();
    test_simultaneous();
    test_out_of_range();
    test_wide();
    test_reset_mid_sequence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
